// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access unit: request size
// encodings, FSM state encoding, byte-enable base patterns and the
// alignment check used at request acceptance.
package dmem_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  // req_size encodings
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  // Byte-enable base patterns, shifted left by the byte offset
  localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
  localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // True when the access cannot be served as a single aligned word access
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = (off != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Bus interfaces of the data-memory access unit.
//   dmem_core_if : core-side request/response (master = core, slave = unit)
//   dmem_mem_if  : memory-side access port (master = unit, slave = memory)
interface dmem_core_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface dmem_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering.
//   Write path: wr_size/wr_off/wr_we/wr_data -> be_c (byte enables),
//               wdata_rep_c (store data replicated across lanes).
//   Read path:  rd_size/rd_off/rd_data -> rdata_c (selected lanes shifted
//               to bit 0, bits above the access size zeroed).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]      wr_size,
  input  logic [1:0]      wr_off,
  input  logic            wr_we,
  input  logic [XLEN-1:0] wr_data,
  output logic [BE_W-1:0] be_c,
  output logic [XLEN-1:0] wdata_rep_c,
  input  logic [1:0]      rd_size,
  input  logic [1:0]      rd_off,
  input  logic [XLEN-1:0] rd_data,
  output logic [XLEN-1:0] rdata_c
);

  logic [XLEN-1:0] rd_shift;

  // Loads always fetch the full word; stores enable only their lanes
  always_comb begin
    be_c        = BE_WORD;
    wdata_rep_c = wr_data;
    if (wr_we) begin
      case (wr_size)
        SIZE_BYTE: begin
          be_c        = BE_BYTE << wr_off;
          wdata_rep_c = {4{wr_data[7:0]}};
        end
        SIZE_HALF: begin
          be_c        = BE_HALF << wr_off;
          wdata_rep_c = {2{wr_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Right-justify the addressed lanes, then mask to the access size
  always_comb begin
    rd_shift = rd_data >> {rd_off, 3'b000};
    case (rd_size)
      SIZE_BYTE: rdata_c = {24'h0, rd_shift[7:0]};
      SIZE_HALF: rdata_c = {16'h0, rd_shift[15:0]};
      default:   rdata_c = rd_shift;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: accepts one core load/store at a time, rejects
// misaligned or illegal-size requests with an error response, otherwise
// issues a single word access to memory and returns a one-cycle response.
// Ports: clk, rst (synchronous, active-high); core (dmem_core_if.slave:
// req_*/resp_*); mem (dmem_mem_if.master: mem_*).
// Optional feature: define DMEM_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES cycles without mem_ack (error response).
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic        clk,
  input logic        rst,
  dmem_core_if.slave core,
  dmem_mem_if.master mem
);

  state_e state_q, state_nxt;

  logic            ready_q,      ready_nxt;
  logic            resp_valid_q, resp_valid_nxt;
  logic            resp_err_q,   resp_err_nxt;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_nxt;
  logic            mem_req_q,    mem_req_nxt;
  logic            mem_we_q,     mem_we_nxt;
  logic [XLEN-1:0] mem_addr_q,   mem_addr_nxt;
  logic [BE_W-1:0] mem_be_q,     mem_be_nxt;
  logic [XLEN-1:0] mem_wdata_q,  mem_wdata_nxt;
  logic [1:0]      size_q,       size_nxt;
  logic [1:0]      off_q,        off_nxt;

  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] wdata_rep_c;
  logic [XLEN-1:0] rdata_c;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
`endif

  // Write lanes come from the live request; read lanes from the latched one
  dmem_lane_align u_align (
    .wr_size     (core.req_size),
    .wr_off      (core.req_addr[1:0]),
    .wr_we       (core.req_we),
    .wr_data     (core.req_wdata),
    .be_c        (be_c),
    .wdata_rep_c (wdata_rep_c),
    .rd_size     (size_q),
    .rd_off      (off_q),
    .rd_data     (mem.mem_rdata),
    .rdata_c     (rdata_c)
  );

  // Next-state and registered-output values
  always_comb begin
    state_nxt      = state_q;
    resp_valid_nxt = 1'b0;
    resp_err_nxt   = 1'b0;
    resp_rdata_nxt = resp_rdata_q;
    mem_req_nxt    = mem_req_q;
    mem_we_nxt     = mem_we_q;
    mem_addr_nxt   = mem_addr_q;
    mem_be_nxt     = mem_be_q;
    mem_wdata_nxt  = mem_wdata_q;
    size_nxt       = size_q;
    off_nxt        = off_q;
`ifdef DMEM_TIMEOUT_EN
    cnt_nxt        = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (core.req_valid && ready_q) begin
          if (is_misaligned(core.req_size, core.req_addr[1:0])) begin
            state_nxt      = ST_RESP;
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
            resp_rdata_nxt = '0;
          end else begin
            state_nxt     = ST_ACCESS;
            mem_req_nxt   = 1'b1;
            mem_we_nxt    = core.req_we;
            mem_addr_nxt  = {core.req_addr[31:2], 2'b00};
            mem_be_nxt    = be_c;
            mem_wdata_nxt = wdata_rep_c;
            size_nxt      = core.req_size;
            off_nxt       = core.req_addr[1:0];
          end
        end
      end

      ST_ACCESS: begin
        // mem_ack takes priority over a timeout hitting in the same cycle
        if (mem.mem_ack) begin
          state_nxt      = ST_RESP;
          mem_req_nxt    = 1'b0;
          mem_we_nxt     = 1'b0;
          resp_valid_nxt = 1'b1;
          resp_rdata_nxt = mem_we_q ? '0 : rdata_c;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt      = ST_RESP;
          mem_req_nxt    = 1'b0;
          mem_we_nxt     = 1'b0;
          resp_valid_nxt = 1'b1;
          resp_err_nxt   = 1'b1;
          resp_rdata_nxt = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
`endif
      end

      ST_RESP: state_nxt = ST_IDLE;

      default: state_nxt = ST_IDLE;
    endcase

    ready_nxt = (state_nxt == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      size_q       <= SIZE_BYTE;
      off_q        <= 2'b00;
`ifdef DMEM_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_nxt;
      ready_q      <= ready_nxt;
      resp_valid_q <= resp_valid_nxt;
      resp_err_q   <= resp_err_nxt;
      resp_rdata_q <= resp_rdata_nxt;
      mem_req_q    <= mem_req_nxt;
      mem_we_q     <= mem_we_nxt;
      mem_addr_q   <= mem_addr_nxt;
      mem_be_q     <= mem_be_nxt;
      mem_wdata_q  <= mem_wdata_nxt;
      size_q       <= size_nxt;
      off_q        <= off_nxt;
`ifdef DMEM_TIMEOUT_EN
      cnt_q        <= cnt_nxt;
`endif
    end
  end

  assign core.req_ready  = ready_q;
  assign core.resp_valid = resp_valid_q;
  assign core.resp_err   = resp_err_q;
  assign core.resp_rdata = resp_rdata_q;
  assign mem.mem_req     = mem_req_q;
  assign mem.mem_we      = mem_we_q;
  assign mem.mem_addr    = mem_addr_q;
  assign mem.mem_be      = mem_be_q;
  assign mem.mem_wdata   = mem_wdata_q;

endmodule
